// File: rtl/cordic_linear_pkg.sv
// Purpose: shared op codes, FSM state encoding and request-error helper for the linear CORDIC control unit.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cordic_linear_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_DIV   = 2'd1,
    OP_RECIP = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  // A request that must never reach the core: reserved op, or divide by zero.
  function automatic logic op_is_err(input logic [1:0] op, input logic den_zero);
    return (op == OP_RSVD) || ((op == OP_DIV) && den_zero);
  endfunction

endpackage

// File: rtl/cordic_wait_timer.sv
// Purpose: saturating WAIT-state cycle counter with clear/enable and an expire flag.
// Latency: expire is combinational from the count; count updates one cycle after en.
// Backpressure: none; pure counter.
// Ports: clk, rst (sync active-low), clr (zero the count), en (count this cycle),
//        expire (count == LIMIT-1, i.e. high in the LIMIT-th enabled cycle after clr).
module cordic_wait_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/linear_cordic_seq_cu.sv
// Purpose: sequences MUL/DIV/RECIP requests through the shared linear CORDIC core, returns tag/op/err.
// Latency: accept->out_valid = 3 + N (done in N-th WAIT cycle); 1 cycle for rejected requests.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE or on a same-cycle release.
// Ports: clk, rst (sync active-low); request in_valid/in_ready/in_op/in_tag/den_zero;
//        core controls loadX/loadY/selY_one/start_cordic/abort_cordic, done_cordic;
//        result out_valid/out_ready/out_tag/out_op/out_err/out_timeout; busy.
// Build option: LINEAR_CORDIC_TIMEOUT_EN adds the WAIT watchdog (abort after TIMEOUT cycles).
module linear_cordic_seq_cu
  import cordic_linear_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             den_zero,
  output logic             loadX,
  output logic             loadY,
  output logic             selY_one,
  output logic             start_cordic,
  output logic             abort_cordic,
  input  logic             done_cordic,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_op,
  output logic             out_err,
  output logic             out_timeout,
  output logic             busy
);

  state_e           state, state_nxt;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             tmo_q;
  logic             take;
  logic             req_bad;
  logic             expire;
  logic             tmo_hit;

`ifdef LINEAR_CORDIC_TIMEOUT_EN
  cordic_wait_timer #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_START),
    .en     (state == ST_WAIT),
    .expire (expire)
  );
`else
  logic [TIMEOUT_W-1:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT);
  assign expire             = 1'b0;
`endif

  // Release of the held result and acceptance of the next request share one edge.
  assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign take     = in_valid && in_ready;
  assign req_bad  = op_is_err(in_op, den_zero);

  // Watchdog loses to a coincident done, so the abort pulse looks at done_cordic.
  assign tmo_hit      = (state == ST_WAIT) && expire && !done_cordic;
  assign abort_cordic = tmo_hit;

  assign out_tag     = tag_q;
  assign out_op      = op_q;
  assign out_err     = err_q;
  assign out_timeout = tmo_q;

  always_comb begin
    state_nxt    = state;
    loadX        = 1'b0;
    loadY        = 1'b0;
    selY_one     = 1'b0;
    start_cordic = 1'b0;
    out_valid    = 1'b0;
    busy         = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (take) state_nxt = req_bad ? ST_HOLD : ST_LOAD;
      end
      ST_LOAD: begin
        loadX     = 1'b1;
        loadY     = 1'b1;
        selY_one  = (op_q == OP_RECIP);
        state_nxt = ST_START;
      end
      ST_START: begin
        start_cordic = 1'b1;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_cordic || tmo_hit) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (take) begin
          state_nxt = req_bad ? ST_HOLD : ST_LOAD;
        end else if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      tag_q <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_q  <= in_op;
        tag_q <= in_tag;
        err_q <= req_bad;
        tmo_q <= 1'b0;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
        tmo_q <= 1'b1;
      end
    end
  end

endmodule
